// File: rtl/exgcd_pkg.sv
// Shared types and defaults for the extended-Euclid engine.
package exgcd_pkg;

  localparam int EXGCD_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bezout coefficients need two guard bits beyond the operand width.
  typedef logic signed [EXGCD_WIDTH+1:0] coef_t;

endpackage

// File: rtl/exgcd_if.sv
// Request/result bundle of the extended-Euclid engine; coef_y exists only with EXGCD_BEZOUT_Y_EN.
interface exgcd_if
  import exgcd_pkg::*;
#(
  parameter int WIDTH = EXGCD_WIDTH
) ();

  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             valid_in;
  logic [WIDTH-1:0] gcd;
  logic [WIDTH-1:0] inv;
  logic             valid_out;
`ifdef EXGCD_BEZOUT_Y_EN
  logic [WIDTH-1:0] coef_y;
`endif

`ifdef EXGCD_BEZOUT_Y_EN
  modport master (output data_a, data_b, valid_in, input gcd, inv, valid_out, coef_y);
  modport slave  (input data_a, data_b, valid_in, output gcd, inv, valid_out, coef_y);
`else
  modport master (output data_a, data_b, valid_in, input gcd, inv, valid_out);
  modport slave  (input data_a, data_b, valid_in, output gcd, inv, valid_out);
`endif

endinterface

// File: rtl/exgcd_divmod.sv
// Combinational unsigned restoring array divider: quotient and remainder of num/den.
// A zero divisor yields meaningless outputs; callers never use them.
module exgcd_divmod #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] num_i,
  input  logic [WIDTH-1:0] den_i,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);

  logic [WIDTH:0] part;

  always_comb begin
    part  = '0;
    quo_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      part = {part[WIDTH-1:0], num_i[i]};
      if (part >= {1'b0, den_i}) begin
        part     = part - {1'b0, den_i};
        quo_o[i] = 1'b1;
      end
    end
    rem_o = part[WIDTH-1:0];
  end

endmodule

// File: rtl/exgcd_recursive.sv
// Iterative extended Euclid: one remainder step per clock, gcd and Bezout x (plus y when
// EXGCD_BEZOUT_Y_EN is defined) registered on completion with a one-cycle valid_out pulse.
module exgcd_recursive
  import exgcd_pkg::*;
#(
  parameter int WIDTH = EXGCD_WIDTH
) (
  input logic    clk,
  input logic    rst_n,
  exgcd_if.slave bus
);

  localparam int CW = WIDTH + 2;

  state_t                state_q;
  logic [WIDTH-1:0]      r0_q, r1_q;
  logic signed [CW-1:0]  s0_q, s1_q;
  logic [WIDTH-1:0]      gcd_q, inv_q;
  logic                  vld_q;

  logic [WIDTH-1:0]      quo, rem;
  logic signed [CW-1:0]  s1_d;

  exgcd_divmod #(.WIDTH(WIDTH)) u_divmod (
    .num_i (r0_q),
    .den_i (r1_q),
    .quo_o (quo),
    .rem_o (rem)
  );

  // Modular CW-bit arithmetic is exact because |s| never exceeds b/g.
  assign s1_d = s0_q - $signed({2'b00, quo}) * s1_q;

`ifdef EXGCD_BEZOUT_Y_EN
  logic signed [CW-1:0]  t0_q, t1_q;
  logic signed [CW-1:0]  t1_d;
  logic [WIDTH-1:0]      y_q;

  assign t1_d = t0_q - $signed({2'b00, quo}) * t1_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      t0_q <= '0;
      t1_q <= '0;
      y_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.valid_in) begin
          t0_q <= '0;
          t1_q <= CW'(1);
        end
        RUN: begin
          if (r1_q != '0) begin
            t0_q <= t1_q;
            t1_q <= t1_d;
          end else begin
            y_q <= t0_q[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.coef_y = y_q;
`endif

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      r0_q    <= '0;
      r1_q    <= '0;
      s0_q    <= '0;
      s1_q    <= '0;
      gcd_q   <= '0;
      inv_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.valid_in) begin
            r0_q    <= bus.data_a;
            r1_q    <= bus.data_b;
            s0_q    <= CW'(1);
            s1_q    <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (r1_q != '0) begin
            r0_q <= r1_q;
            r1_q <= rem;
            s0_q <= s1_q;
            s1_q <= s1_d;
          end else begin
            gcd_q   <= r0_q;
            inv_q   <= s0_q[WIDTH-1:0];
            vld_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gcd       = gcd_q;
  assign bus.inv       = inv_q;
  assign bus.valid_out = vld_q;

endmodule

// File: tb/tb_exgcd_recursive.sv
// Directed and random checks of the extended-Euclid engine.
module tb_exgcd_recursive;
  import exgcd_pkg::*;

  localparam int W = EXGCD_WIDTH;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  exgcd_if #(.WIDTH(W)) bus ();

  exgcd_recursive #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int ref_gcd(input int a, input int b);
    int x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Launch one request and wait for valid_out; lat = edges after the accept edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output bit seen);
    @(negedge clk);
    bus.data_a   = a;
    bus.data_b   = b;
    bus.valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.valid_in = 1'b0;
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c < 40; c++) begin
      if (bus.valid_out) begin
        seen = 1'b1;
        lat  = c;
        break;
      end
      @(negedge clk);
    end
    if (!seen) check("timeout", 32'd0, 32'd1);
  endtask

  task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eg, input logic [W-1:0] ei);
    int lat;
    bit seen;
    run_op(a, b, lat, seen);
    check({tag, "_gcd"}, 32'(bus.gcd), 32'(eg));
    check({tag, "_inv"}, 32'(bus.inv), 32'(ei));
`ifdef EXGCD_BEZOUT_Y_EN
    check({tag, "_bez_y"}, 32'(int'(a) * int'($signed(bus.inv)) + int'(b) * int'($signed(bus.coef_y))),
          32'(eg));
`endif
    @(negedge clk);
    check({tag, "_pulse"}, 32'(bus.valid_out), 32'd0);
    check({tag, "_hold"}, 32'(bus.gcd), 32'(eg));
  endtask

  initial begin
    int lat;
    bit seen;
    int g, sx;
    logic [W-1:0] ra, rb;

    n_chk        = 0;
    n_fail       = 0;
    bus.data_a   = '0;
    bus.data_b   = '0;
    bus.valid_in = 1'b0;
    rst_n        = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gcd", 32'(bus.gcd), 32'd0);
    check("rst_inv", 32'(bus.inv), 32'd0);
    check("rst_vld", 32'(bus.valid_out), 32'd0);
    rst_n = 1'b0;

    directed("a15b24",  8'd15,  8'd24,  8'd3,   8'hFD);
    directed("a9b7",    8'd9,   8'd7,   8'd1,   8'hFD);
    directed("a27b81",  8'd27,  8'd81,  8'd27,  8'd1);
    directed("a27b12",  8'd27,  8'd12,  8'd3,   8'd1);
    directed("a0b0",    8'd0,   8'd0,   8'd0,   8'd1);
    directed("a200b0",  8'd200, 8'd0,   8'd200, 8'd1);
    directed("a0b5",    8'd0,   8'd5,   8'd5,   8'd0);

    // Fibonacci pair gives the longest remainder chain at 8 bits.
    run_op(8'd233, 8'd144, lat, seen);
    check("fib_gcd", 32'(bus.gcd), 32'd1);
    check("fib_inv", 32'(bus.inv), 32'hC9);
    check("fib_lat_bound", 32'(lat < 16), 32'd1);

    // A second request during RUN must not disturb the running one.
    @(negedge clk);
    bus.data_a   = 8'd233;
    bus.data_b   = 8'd144;
    bus.valid_in = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0;
    repeat (3) @(negedge clk);
    bus.data_a   = 8'd9;
    bus.data_b   = 8'd7;
    bus.valid_in = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      if (bus.valid_out) seen = 1'b1;
      else @(negedge clk);
    end
    check("ign_seen", 32'(seen), 32'd1);
    check("ign_inv", 32'(bus.inv), 32'hC9);
    @(negedge clk);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.valid_out) seen = 1'b1;
      @(negedge clk);
    end
    check("ign_no_second", 32'(seen), 32'd0);

    // Reset in the middle of a run clears outputs and suppresses completion.
    bus.data_a   = 8'd233;
    bus.data_b   = 8'd144;
    bus.valid_in = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    check("mrst_gcd", 32'(bus.gcd), 32'd0);
    check("mrst_inv", 32'(bus.inv), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.valid_out) seen = 1'b1;
      @(negedge clk);
    end
    check("mrst_no_vld", 32'(seen), 32'd0);
    directed("post_rst", 8'd9, 8'd7, 8'd1, 8'hFD);

    // Random sweep: gcd against a plain Euclid, x checked through the Bezout identity.
    for (int k = 0; k < 24; k++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      if (k == 0) rb = '0;
      run_op(ra, rb, lat, seen);
      g  = ref_gcd(int'(ra), int'(rb));
      sx = int'($signed(bus.inv));
      check("rnd_gcd", 32'(bus.gcd), 32'(g));
      if (rb == '0) check("rnd_inv_b0", 32'(bus.inv), 32'd1);
      else check("rnd_bezout", 32'((g - int'(ra) * sx) % int'(rb)), 32'd0);
      check("rnd_lat", 32'(lat < 16), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
